gemac_rx_axis: RTL and testbench

Receive-side client adapter sitting directly downstream of the GEMAC RX client interface (rx_data/rx_valid/rx_error/rx_ack). The MAC cannot be stalled, so this block converts its byte stream into an 8-bit AXI-stream with tlast/tuser and absorbs downstream backpressure. It truncates and error-marks frames that overrun the output, discards frames that cannot start, and keeps per-frame status counters.

---
 rtl/gemac_rx_axis.sv | 186 ++++++++++++++++++
 tb/tb_gemac_rx_axis.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gemac_rx_axis.sv
// gemac_rx_axis: GEMAC rx client -> 8-bit AXI-stream adapter. The MAC cannot
// be stalled, so backpressure is absorbed by truncating (tuser=1) or dropping
// frames. Ports: clk, reset (async, active-high), clear (sync flush);
// rx_data/rx_valid/rx_ack/rx_error from the MAC; o_tdata/o_tlast/o_tuser/
// o_tvalid/o_tready downstream; good_cnt/bad_cnt/ovr_cnt/drop_cnt status.
// Define GEMAC_RX_AXIS_CNT_EN to build the status counters (else tied to 0).
module gemac_rx_axis (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_ack,
  input  logic        rx_error,
  output logic [7:0]  o_tdata,
  output logic        o_tlast,
  output logic        o_tuser,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
  output logic [15:0] ovr_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_DROP,
    S_TERM,
    S_SKIP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  h_q, h_nxt;
  logic [7:0]  td_nxt;
  logic        tl_nxt, tu_nxt, tv_nxt;
  logic        flag_q, flag_nxt;
  logic        skip_q, skip_nxt;
  logic        end_p, o_free;

  assign end_p  = rx_ack | rx_error;
  assign o_free = !o_tvalid || o_tready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      h_q      <= '0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_tuser  <= 1'b0;
      o_tvalid <= 1'b0;
      flag_q   <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      h_q      <= h_nxt;
      o_tdata  <= td_nxt;
      o_tlast  <= tl_nxt;
      o_tuser  <= tu_nxt;
      o_tvalid <= tv_nxt;
      flag_q   <= flag_nxt;
      skip_q   <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    h_nxt     = h_q;
    td_nxt    = o_tdata;
    tl_nxt    = o_tlast;
    tu_nxt    = o_tuser;
    tv_nxt    = o_tvalid && !o_tready;
    flag_nxt  = flag_q;
    skip_nxt  = skip_q;
    if (clear) begin
      state_nxt = S_IDLE;
      td_nxt    = '0;
      tl_nxt    = 1'b0;
      tu_nxt    = 1'b0;
      tv_nxt    = 1'b0;
      flag_nxt  = 1'b0;
      skip_nxt  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          // a byte arriving with an end pulse is discarded
          if (rx_valid && !end_p) begin
            h_nxt     = rx_data;
            state_nxt = S_XFER;
          end
        end
        S_XFER: begin
          if (end_p) begin
            flag_nxt  = rx_error;
            state_nxt = S_TERM;
          end else if (rx_valid) begin
            if (o_free) begin
              td_nxt = h_q;
              tl_nxt = 1'b0;
              tu_nxt = 1'b0;
              tv_nxt = 1'b1;
              h_nxt  = rx_data;
            end else begin
              // H keeps the byte that will close the frame
              state_nxt = S_DROP;
            end
          end
        end
        S_DROP: begin
          if (end_p) begin
            flag_nxt  = 1'b1;
            state_nxt = S_TERM;
          end
        end
        S_TERM: begin
          if (o_free) begin
            td_nxt   = h_q;
            tl_nxt   = 1'b1;
            tu_nxt   = flag_q;
            tv_nxt   = 1'b1;
            skip_nxt = 1'b0;
            if (skip_q) begin
              state_nxt = end_p ? S_IDLE : S_SKIP;
            end else if (rx_valid && !end_p) begin
              h_nxt     = rx_data;
              state_nxt = S_XFER;
            end else begin
              state_nxt = S_IDLE;
            end
          end else if (end_p) begin
            // the frame lost while stalled has now ended
            skip_nxt = 1'b0;
          end else if (rx_valid && !skip_q) begin
            skip_nxt = 1'b1;
          end
        end
        S_SKIP: begin
          if (end_p) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef GEMAC_RX_AXIS_CNT_EN
  logic        emit_last;
  logic        inc_good, inc_bad, inc_ovr, inc_drop;
  logic [15:0] good_q, bad_q, ovr_q, drop_q;

  assign emit_last = !clear && state == S_TERM && o_free;
  assign inc_good  = emit_last && !flag_q;
  assign inc_bad   = emit_last && flag_q;
  assign inc_ovr   = !clear && state == S_XFER && rx_valid &&
                     !end_p && !o_free;
  assign inc_drop  = !clear && state == S_TERM && !o_free &&
                     rx_valid && !end_p && !skip_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_q <= '0;
      bad_q  <= '0;
      ovr_q  <= '0;
      drop_q <= '0;
    end else begin
      if (inc_good) good_q <= good_q + 16'd1;
      if (inc_bad)  bad_q  <= bad_q + 16'd1;
      if (inc_ovr)  ovr_q  <= ovr_q + 16'd1;
      if (inc_drop) drop_q <= drop_q + 16'd1;
    end
  end

  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;
  assign ovr_cnt  = ovr_q;
  assign drop_cnt = drop_q;
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
  assign ovr_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_gemac_rx_axis.sv
// tb_gemac_rx_axis: directed bench for gemac_rx_axis.
// Accepted beats are queued and compared with hand-built frames.
module tb_gemac_rx_axis;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ack = 1'b0;
  logic        rx_error = 1'b0;
  logic [7:0]  o_tdata;
  logic        o_tlast, o_tuser, o_tvalid;
  logic        o_tready = 1'b1;
  logic [15:0] good_cnt, bad_cnt, ovr_cnt, drop_cnt;

  int checks = 0;
  int failures = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  gemac_rx_axis dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .rx_error (rx_error),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tuser  (o_tuser),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .good_cnt (good_cnt),
    .bad_cnt  (bad_cnt),
    .ovr_cnt  (ovr_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // beat is accepted at the coming posedge
  always @(negedge clk)
    if (!reset && o_tvalid && o_tready)
      got_q.push_back({o_tlast, o_tuser, o_tdata});

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ce(input logic [15:0] v);
`ifdef GEMAC_RX_AXIS_CNT_EN
    return v;
`else
    return 16'd0;
`endif
  endfunction

  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic a, input logic e,
                     input logic r, input logic c);
    rx_valid = v;
    rx_data  = d;
    rx_ack   = a;
    rx_error = e;
    o_tready = r;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 8'h00, 0, 0, 1, 0);
  endtask

  task automatic frame(input int n, input logic [7:0] base,
                       input logic err);
    for (int i = 0; i < n; i++)
      cyc(1, 8'(base + i), 0, 0, 1, 0);
    idle(1);
    cyc(0, 8'h00, !err, err, 1, 0);
    idle(4);
  endtask

  task automatic exp_frame(input int n, input logic [7:0] base,
                           input logic user);
    for (int i = 0; i < n; i++)
      exp_q.push_back({i == n - 1, (i == n - 1) && user,
                       8'(base + i)});
  endtask

  task automatic cmp_beats(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]),
            32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_cnt(input string tag,
                         input logic [15:0] g, input logic [15:0] b,
                         input logic [15:0] o, input logic [15:0] d);
    check({tag, "_good"}, good_cnt, ce(g));
    check({tag, "_bad"}, bad_cnt, ce(b));
    check({tag, "_ovr"}, ovr_cnt, ce(o));
    check({tag, "_drop"}, drop_cnt, ce(d));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    do_reset();
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tdata", o_tdata, 0);
    check("rst_tlast", o_tlast, 0);
    check("rst_tuser", o_tuser, 0);
    chk_cnt("rst", 0, 0, 0, 0);

    // good 64-byte frame, with first-beat latency probe
    for (int i = 0; i < 64; i++) begin
      cyc(1, 8'(i), 0, 0, 1, 0);
      if (i == 0) check("lat_b0_tvalid", o_tvalid, 0);
      if (i == 1) begin
        check("lat_b1_tvalid", o_tvalid, 1);
        check("lat_b1_tdata", o_tdata, 0);
      end
    end
    idle(1);
    cyc(0, 8'h00, 1, 0, 1, 0);
    idle(4);
    exp_frame(64, 8'h00, 0);
    cmp_beats("good64");
    chk_cnt("good64", 1, 0, 0, 0);

    // same frame ended with rx_error
    do_reset();
    frame(64, 8'h00, 1);
    exp_frame(64, 8'h00, 1);
    cmp_beats("err64");
    chk_cnt("err64", 0, 1, 0, 0);

    // overrun: ready low for byte cycles 11..15
    do_reset();
    for (int i = 0; i < 16; i++)
      cyc(1, 8'(i), 0, 0, (i <= 10), 0);
    idle(1);
    cyc(0, 8'h00, 1, 0, 1, 0);
    idle(4);
    exp_frame(10, 8'h00, 0);
    void'(exp_q.pop_back());
    exp_q.push_back({1'b0, 1'b0, 8'h09});
    exp_q.push_back({1'b1, 1'b1, 8'h0A});
    cmp_beats("ovr");
    chk_cnt("ovr", 0, 1, 1, 0);

    // stall across a frame boundary: second frame dropped
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(1, 8'(8'h10 + i), 0, 0, 1, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(1, 8'(8'h20 + i), 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    repeat (12) cyc(0, 8'h00, 0, 0, 0, 0);
    idle(4);
    frame(3, 8'h30, 0);
    exp_frame(4, 8'h10, 0);
    exp_frame(3, 8'h30, 0);
    cmp_beats("drop");
    chk_cnt("drop", 2, 0, 0, 1);

    // byte concurrent with ack is lost; ack+error is an error
    for (int i = 0; i < 3; i++)
      cyc(1, 8'(8'h40 + i), 0, 0, 1, 0);
    cyc(1, 8'h99, 1, 0, 1, 0);
    idle(3);
    for (int i = 0; i < 2; i++)
      cyc(1, 8'(8'h50 + i), 0, 0, 1, 0);
    cyc(0, 8'h00, 1, 1, 1, 0);
    idle(4);
    exp_frame(3, 8'h40, 0);
    exp_frame(2, 8'h50, 1);
    cmp_beats("conc");
    chk_cnt("conc", 3, 1, 0, 1);

    // clear at byte 20, trailing ack is stray
    for (int i = 0; i < 21; i++)
      cyc(1, 8'(i), 0, 0, 1, (i == 20));
    check("clr_tvalid", o_tvalid, 0);
    cyc(0, 8'h00, 1, 0, 1, 0);
    idle(4);
    exp_frame(19, 8'h00, 0);
    void'(exp_q.pop_back());
    exp_q.push_back({1'b0, 1'b0, 8'h12});
    cmp_beats("clr");
    chk_cnt("clr", 3, 1, 0, 1);
    frame(8, 8'h60, 0);
    exp_frame(8, 8'h60, 0);
    cmp_beats("post_clr");
    chk_cnt("post_clr", 4, 1, 0, 1);

    // reset mid-frame zeroes everything
    for (int i = 0; i < 5; i++)
      cyc(1, 8'(8'h70 + i), 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("rst_mid_tvalid", o_tvalid, 0);
    idle(2);
    reset = 1'b0;
    idle(2);
    chk_cnt("rst_mid", 0, 0, 0, 0);
    got_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
